instr_queue: RTL and testbench

- Multi-entry circular FIFO between decode and rename/dispatch.
- Accepts 0..INSTR_Q_WIDTH decoded uops per cycle from decode.
- Presents up to INSTR_Q_WIDTH oldest uops per cycle to the downstream consumer, which pops any prefix of them.
- Flushed on branch mispredict or exception.

---
 rtl/uop_pkg.sv | 18 +
 rtl/instr_queue.sv | 96 +++++++++
 tb/tb_instr_queue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uop_pkg.sv
// Shared uop type, instruction-queue sizing defaults and the pointer wrap helper
// used between decode and rename/dispatch.
package uop_pkg;

  localparam int INSTR_Q_DEPTH = 16;
  localparam int INSTR_Q_WIDTH = 2;
  localparam int UOP_W         = 32;

  typedef logic [UOP_W-1:0] uop_insn;

  // Depth is a power of two, so wrapping is a mask of the low bits.
  function automatic int unsigned wrap_inc(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    return (ptr + inc) & (depth - 1);
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Circular uop FIFO between decode and rename/dispatch: up to WIDTH pushes and
// pops per cycle, combinational dequeue view, sync flush and sticky overflow flag.
module instr_queue #(
  parameter int INSTR_Q_DEPTH = uop_pkg::INSTR_Q_DEPTH,
  parameter int INSTR_Q_WIDTH = uop_pkg::INSTR_Q_WIDTH,
  parameter int CNT_W         = $clog2(INSTR_Q_DEPTH + 1),
  parameter int PORT_W        = $clog2(INSTR_Q_WIDTH + 1)
) (
  input  logic                                    clk_in,
  input  logic                                    rst_N_in,
  input  logic                                    flush_in,
  output logic                                    enq_ready_out,
  input  logic [PORT_W-1:0]                       enq_count_in,
  input  uop_pkg::uop_insn [INSTR_Q_WIDTH-1:0]    enq_data_in,
  output logic [PORT_W-1:0]                       deq_valid_count_out,
  output uop_pkg::uop_insn [INSTR_Q_WIDTH-1:0]    deq_data_out,
  input  logic [PORT_W-1:0]                       deq_pop_in,
  output logic [CNT_W-1:0]                        occupancy_out,
  output logic                                    overflow_err_out
);

  import uop_pkg::*;

  localparam int PTR_W = $clog2(INSTR_Q_DEPTH);

  uop_insn          mem [INSTR_Q_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic [CNT_W-1:0]  free;
  logic [CNT_W-1:0]  push_req;
  logic              push_ok;
  logic              overflow_hit;
  logic [PORT_W-1:0] eff_pop;
  logic [CNT_W-1:0]  push_n;
  logic [CNT_W-1:0]  pop_n;

  // Space is judged on registered count only; same-cycle pops never make room.
  assign free     = CNT_W'(INSTR_Q_DEPTH) - count;
  assign push_req = CNT_W'(enq_count_in);

  assign enq_ready_out = (free >= CNT_W'(INSTR_Q_WIDTH));

  // Any group wider than a port or larger than the free space is dropped whole.
  assign push_ok      = !flush_in && (push_req <= free) &&
                        (push_req <= CNT_W'(INSTR_Q_WIDTH));
  assign overflow_hit = !flush_in && !push_ok;

  assign deq_valid_count_out = (count >= CNT_W'(INSTR_Q_WIDTH)) ?
                               PORT_W'(INSTR_Q_WIDTH) : PORT_W'(count);
  assign eff_pop = (deq_pop_in > deq_valid_count_out) ?
                   deq_valid_count_out : deq_pop_in;

  assign push_n = push_ok ? push_req : '0;
  assign pop_n  = CNT_W'(eff_pop);

  assign occupancy_out    = count;
  assign overflow_err_out = overflow;

  always_comb begin
    deq_data_out = '0;
    for (int i = 0; i < INSTR_Q_WIDTH; i++) begin
      deq_data_out[i] = mem[PTR_W'(wrap_inc(32'(head), i, INSTR_Q_DEPTH))];
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head     <= PTR_W'(wrap_inc(32'(head), 32'(pop_n), INSTR_Q_DEPTH));
      tail     <= PTR_W'(wrap_inc(32'(tail), 32'(push_n), INSTR_Q_DEPTH));
      count    <= count + push_n - pop_n;
      overflow <= overflow | overflow_hit;
    end
  end

  // Storage keeps its contents across reset and flush; only pointers move.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < INSTR_Q_WIDTH; i++) begin
      if (push_ok && (PORT_W'(i) < enq_count_in)) begin
        mem[PTR_W'(wrap_inc(32'(tail), i, INSTR_Q_DEPTH))] <= enq_data_in[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue at DEPTH=8, WIDTH=2: directed scenarios with literal
// checks, then random traffic against a queue-based reference model.
module tb_instr_queue;

  import uop_pkg::*;

  localparam int DEPTH  = 8;
  localparam int W      = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PORT_W = $clog2(W + 1);

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic                      enq_ready;
  logic [PORT_W-1:0]         enq_count;
  uop_insn [W-1:0]           enq_data;
  logic [PORT_W-1:0]         deq_valid;
  uop_insn [W-1:0]           deq_data;
  logic [PORT_W-1:0]         deq_pop;
  logic [CNT_W-1:0]          occupancy;
  logic                      overflow_err;

  logic [31:0] exp_q[$];
  logic        exp_err;
  logic        chk_en;
  int          tests;
  int          fails;

  instr_queue #(
    .INSTR_Q_DEPTH(DEPTH),
    .INSTR_Q_WIDTH(W)
  ) dut (
    .clk_in              (clk),
    .rst_N_in            (rst_n),
    .flush_in            (flush),
    .enq_ready_out       (enq_ready),
    .enq_count_in        (enq_count),
    .enq_data_in         (enq_data),
    .deq_valid_count_out (deq_valid),
    .deq_data_out        (deq_data),
    .deq_pop_in          (deq_pop),
    .occupancy_out       (occupancy),
    .overflow_err_out    (overflow_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare();
    int sz;
    int vis;
    sz  = exp_q.size();
    vis = (sz < W) ? sz : W;
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("deq_valid", 32'(deq_valid), 32'(vis));
    chk("enq_ready", 32'(enq_ready), 32'((DEPTH - sz) >= W));
    chk("overflow_err", 32'(overflow_err), 32'(exp_err));
    for (int i = 0; i < vis; i++) begin
      chk($sformatf("deq_data[%0d]", i), deq_data[i], exp_q[i]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) compare();
  end

  // ---------------- driver ----------------
  // Applies one cycle of inputs; the model advances at the same edge as the DUT.
  task automatic drive(input logic fl, input int cnt, input logic [31:0] d0,
                       input logic [31:0] d1, input int pop);
    int sz;
    int npop;
    logic [31:0] dv [2];
    dv[0] = d0;
    dv[1] = d1;
    flush       = fl;
    enq_count   = PORT_W'(cnt);
    enq_data[0] = d0;
    enq_data[1] = d1;
    deq_pop     = PORT_W'(pop);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      sz   = exp_q.size();
      npop = (pop < ((sz < W) ? sz : W)) ? pop : ((sz < W) ? sz : W);
      if (cnt > W || cnt > DEPTH - sz) begin
        exp_err = 1'b1;
        cnt     = 0;
      end
      for (int i = 0; i < npop; i++) void'(exp_q.pop_front());
      for (int i = 0; i < cnt; i++) exp_q.push_back(dv[i]);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    flush     = 1'b0;
    enq_count = '0;
    deq_pop   = '0;
    rst_n     = 1'b0;
    #1;
    chk("async_rst occupancy", 32'(occupancy), 32'd0);
    chk("async_rst deq_valid", 32'(deq_valid), 32'd0);
    chk("async_rst enq_ready", 32'(enq_ready), 32'd1);
    chk("async_rst overflow", 32'(overflow_err), 32'd0);
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests     = 0;
    fails     = 0;
    chk_en    = 1'b0;
    exp_err   = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    enq_count = '0;
    enq_data  = '0;
    deq_pop   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset enq_ready", 32'(enq_ready), 32'd1);
    chk("reset deq_valid", 32'(deq_valid), 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    chk("reset overflow", 32'(overflow_err), 32'd0);
    chk_en = 1'b1;

    // Reset mid-stream after three pushes.
    drive(0, 2, 32'h51, 32'h52, 0);
    drive(0, 1, 32'h53, 32'h0, 0);
    chk("pre_rst occupancy", 32'(occupancy), 32'd3);
    rst_pulse();

    // Fill and drain.
    for (int k = 0; k < 4; k++) drive(0, 2, 32'(2*k+1), 32'(2*k+2), 0);
    chk("fill occupancy", 32'(occupancy), 32'd8);
    chk("fill enq_ready", 32'(enq_ready), 32'd0);
    chk("fill deq_valid", 32'(deq_valid), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk("drain lane0", deq_data[0], 32'(2*k+1));
      chk("drain lane1", deq_data[1], 32'(2*k+2));
      drive(0, 0, 32'h0, 32'h0, 2);
    end
    chk("drain occupancy", 32'(occupancy), 32'd0);

    // Wrap straddle: A lands in the last slot, B in slot 0.
    drive(0, 2, 32'd11, 32'd12, 0);
    drive(0, 2, 32'd13, 32'd14, 0);
    drive(0, 2, 32'd15, 32'd16, 0);
    drive(0, 1, 32'd17, 32'd0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 32'h0, 32'h0, 2);
    drive(0, 2, 32'hA, 32'hB, 0);
    chk("wrap lane0", deq_data[0], 32'd17);
    chk("wrap lane1", deq_data[1], 32'hA);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("wrap after pop lane0", deq_data[0], 32'hA);
    chk("wrap after pop lane1", deq_data[1], 32'hB);
    drive(0, 0, 32'h0, 32'h0, 2);
    chk("wrap empty", 32'(occupancy), 32'd0);

    // Simultaneous push/pop at full-1.
    drive(0, 2, 32'd20, 32'd21, 0);
    drive(0, 2, 32'd22, 32'd23, 0);
    drive(0, 2, 32'd24, 32'd25, 0);
    drive(0, 1, 32'd26, 32'd0, 0);
    chk("full-1 occupancy", 32'(occupancy), 32'd7);
    chk("full-1 enq_ready", 32'(enq_ready), 32'd0);
    drive(0, 1, 32'd27, 32'd0, 2);
    chk("push1pop2 occupancy", 32'(occupancy), 32'd6);
    chk("push1pop2 head", deq_data[0], 32'd22);

    // Overflow at occupancy 7.
    drive(0, 1, 32'd28, 32'd0, 0);
    drive(0, 2, 32'h90, 32'h91, 0);
    chk("overflow flag", 32'(overflow_err), 32'd1);
    chk("overflow occupancy", 32'(occupancy), 32'd7);

    // Flush with traffic at occupancy 5, then over-pop on empty.
    drive(0, 0, 32'h0, 32'h0, 2);
    chk("pre_flush occupancy", 32'(occupancy), 32'd5);
    drive(1, 2, 32'h70, 32'h71, 1);
    chk("flush occupancy", 32'(occupancy), 32'd0);
    chk("flush deq_valid", 32'(deq_valid), 32'd0);
    chk("flush keeps overflow", 32'(overflow_err), 32'd1);
    drive(0, 0, 32'h0, 32'h0, 2);
    chk("overpop occupancy", 32'(occupancy), 32'd0);

    // Randomized traffic from a clean reset.
    rst_pulse();
    for (int n = 0; n < 2000; n++) begin
      int c;
      int p;
      logic fl;
      fl = ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 39) == 0) ? 3 : int'($urandom_range(0, 2));
      p  = int'($urandom_range(0, 3));
      if (n == 1000) rst_pulse();
      drive(fl, c, $urandom, $urandom, p);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
